// File: rtl/uart_rx.sv
// 8N1 UART receiver: triple-flop synchroniser, falling-edge start detect,
// mid-bit sampling, one-cycle po_flag / frame_err result pulses.
module uart_rx #(
   parameter int unsigned BIT_CYCLES = 10417
) (
   input  logic       s_clk,
   input  logic       s_rst,
   input  logic       rs232_rx,
   output logic [7:0] rx_data,
   output logic       po_flag,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int unsigned CW   = $clog2(BIT_CYCLES);
   localparam int unsigned HALF = BIT_CYCLES / 2;
   localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] C_BIT_M1  = CW'(BIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_rx_s1;
   logic            r_rx_s2;
   logic            r_rx_s3;
   logic [CW-1:0]   r_baud_cnt;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shreg;
   logic [7:0]      r_rx_data;
   logic            r_po_flag;
   logic            r_frame_err;
   logic            w_fall;
   logic            w_sample;
   logic            w_shift;
   logic            w_good;
   logic            w_bad;

   // Synchroniser resets low, so a start needs the line to be seen high first
   assign w_fall = r_rx_s3 & ~r_rx_s2;

   always_comb begin
      w_state_nxt = r_state;
      w_sample    = 1'b0;
      w_shift     = 1'b0;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_fall) w_state_nxt = S_START;
         end
         S_START: begin
            if (r_baud_cnt == C_HALF_M1) begin
               w_sample    = 1'b1;
               w_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_baud_cnt == C_BIT_M1) begin
               w_sample = 1'b1;
               w_shift  = 1'b1;
               if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            // Leaving at mid-stop-bit lets a back-to-back start edge be caught
            if (r_baud_cnt == C_BIT_M1) begin
               w_sample    = 1'b1;
               w_good      = r_rx_s2;
               w_bad       = ~r_rx_s2;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         r_state     <= S_IDLE;
         r_rx_s1     <= 1'b0;
         r_rx_s2     <= 1'b0;
         r_rx_s3     <= 1'b0;
         r_baud_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shreg     <= '0;
         r_rx_data   <= '0;
         r_po_flag   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_s1 <= rs232_rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
         r_state <= w_state_nxt;

         if ((w_state_nxt != r_state) || w_sample) r_baud_cnt <= '0;
         else                                      r_baud_cnt <= r_baud_cnt + CW'(1);

         if (r_state != S_DATA) r_bit_cnt <= '0;
         else if (w_shift)      r_bit_cnt <= r_bit_cnt + 3'd1;

         if (w_shift) r_shreg <= {r_rx_s2, r_shreg[7:1]};
         if (w_good)  r_rx_data <= r_shreg;

         r_po_flag   <= w_good;
         r_frame_err <= w_bad;
      end
   end

   assign rx_data   = r_rx_data;
   assign po_flag   = r_po_flag;
   assign frame_err = r_frame_err;
   assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frame stimulus for uart_rx; pulses are captured by
// a monitor and compared against timing/data predicted from frame arithmetic.
module tb_uart_rx;

   localparam int unsigned BC  = 16;
   localparam int          LAT = 2 + BC / 2 + 9 * BC;

   logic       s_clk;
   logic       s_rst;
   logic       rs232_rx;
   logic [7:0] rx_data;
   logic       po_flag;
   logic       frame_err;
   logic       rx_busy;

   int total = 0;
   int bad   = 0;
   int edge_no = 0;
   int busy_cnt = 0;
   bit both_seen = 1'b0;

   int         mon_edge[$];
   int         mon_kind[$];
   logic [7:0] mon_data[$];
   int         exp_edge[$];
   int         exp_kind[$];
   logic [7:0] exp_data[$];

   uart_rx #(.BIT_CYCLES(BC)) dut (
      .s_clk    (s_clk),
      .s_rst    (s_rst),
      .rs232_rx (rs232_rx),
      .rx_data  (rx_data),
      .po_flag  (po_flag),
      .frame_err(frame_err),
      .rx_busy  (rx_busy)
   );

   initial s_clk = 1'b0;
   always #5 s_clk = ~s_clk;

   always @(posedge s_clk) edge_no <= edge_no + 1;

   // kind 1 = po_flag, kind 2 = frame_err; rx_data captured in the same cycle
   always @(negedge s_clk) begin
      if (po_flag) begin
         mon_edge.push_back(edge_no); mon_kind.push_back(1); mon_data.push_back(rx_data);
      end
      if (frame_err) begin
         mon_edge.push_back(edge_no); mon_kind.push_back(2); mon_data.push_back(rx_data);
      end
      if (po_flag && frame_err) both_seen = 1'b1;
      if (rx_busy) busy_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge s_clk);
      #1;
   endtask

   task automatic push_exp(input int e, input int kind, input logic [7:0] d);
      exp_edge.push_back(e); exp_kind.push_back(kind); exp_data.push_back(d);
   endtask

   task automatic check_events(input string tag);
      int n;
      chk({tag, ".count"}, mon_edge.size(), exp_edge.size());
      n = (mon_edge.size() < exp_edge.size()) ? mon_edge.size() : exp_edge.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s.ev%0d.edge", tag, i), mon_edge[i], exp_edge[i]);
         chk($sformatf("%s.ev%0d.kind", tag, i), mon_kind[i], exp_kind[i]);
         chk($sformatf("%s.ev%0d.data", tag, i), {24'd0, mon_data[i]}, {24'd0, exp_data[i]});
      end
      mon_edge.delete(); mon_kind.delete(); mon_data.delete();
      exp_edge.delete(); exp_kind.delete(); exp_data.delete();
   endtask

   // Caller is 1 time unit after a posedge; the next posedge is edge k.
   task automatic send_frame(input logic [7:0] b, input logic stop, output int k);
      rs232_rx = 1'b0;
      k = edge_no + 1;
      wait_cycles(BC);
      for (int i = 0; i < 8; i++) begin
         rs232_rx = b[i];
         wait_cycles(BC);
      end
      rs232_rx = stop;
      wait_cycles(BC);
   endtask

   initial begin
      int         k1;
      int         k2;
      int         gap;
      logic [7:0] b;
      logic       stp;
      logic       prev_bad;
      logic [7:0] last_good;

      rs232_rx = 1'b1;
      s_rst    = 1'b1;
      wait_cycles(3);
      s_rst = 1'b0;
      chk("reset.rx_data", {24'd0, rx_data}, 32'h00);
      chk("reset.po_flag", {31'd0, po_flag}, 32'd0);
      chk("reset.frame_err", {31'd0, frame_err}, 32'd0);
      chk("reset.rx_busy", {31'd0, rx_busy}, 32'd0);
      wait_cycles(5);
      mon_edge.delete(); mon_kind.delete(); mon_data.delete();

      // single byte
      busy_cnt = 0;
      send_frame(8'h55, 1'b1, k1);
      push_exp(k1 + LAT, 1, 8'h55);
      wait_cycles(20);
      check_events("single");
      chk("single.busy_cycles", busy_cnt, 152);
      chk("single.rx_data", {24'd0, rx_data}, 32'h55);

      // back-to-back, no idle gap
      send_frame(8'hA5, 1'b1, k1);
      send_frame(8'h3C, 1'b1, k2);
      chk("b2b.frame_spacing", k2 - k1, 10 * BC);
      push_exp(k1 + LAT, 1, 8'hA5);
      push_exp(k1 + 10 * BC + LAT, 1, 8'h3C);
      wait_cycles(20);
      check_events("b2b");

      // glitch
      busy_cnt = 0;
      rs232_rx = 1'b0;
      wait_cycles(4);
      rs232_rx = 1'b1;
      wait_cycles(30);
      check_events("glitch");
      chk("glitch.busy_cycles", busy_cnt, 8);

      // frame error after a good byte, then a long break
      send_frame(8'h12, 1'b1, k1);
      push_exp(k1 + LAT, 1, 8'h12);
      wait_cycles(10);
      send_frame(8'hF0, 1'b0, k2);
      push_exp(k2 + LAT, 2, 8'h12);
      wait_cycles(500);
      check_events("ferr");
      chk("ferr.rx_data_held", {24'd0, rx_data}, 32'h12);
      rs232_rx = 1'b1;
      wait_cycles(40);
      check_events("ferr.after_break");

      // reset during data bit 4 of 8'hF0
      rs232_rx = 1'b0;
      wait_cycles(BC);
      for (int i = 0; i < 4; i++) wait_cycles(BC);
      rs232_rx = 1'b1;
      wait_cycles(8);
      s_rst = 1'b1;
      wait_cycles(1);
      s_rst = 1'b0;
      chk("rstmid.rx_busy", {31'd0, rx_busy}, 32'd0);
      chk("rstmid.rx_data", {24'd0, rx_data}, 32'h00);
      wait_cycles(7 + 4 * BC + 100);
      check_events("rstmid");
      send_frame(8'h81, 1'b1, k1);
      push_exp(k1 + LAT, 1, 8'h81);
      wait_cycles(20);
      check_events("rstmid.next");
      chk("rstmid.next.rx_data", {24'd0, rx_data}, 32'h81);

      // reset released while the line is low
      rs232_rx = 1'b0;
      s_rst = 1'b1;
      wait_cycles(2);
      s_rst = 1'b0;
      busy_cnt = 0;
      wait_cycles(100);
      rs232_rx = 1'b1;
      wait_cycles(40);
      check_events("rstlow");
      chk("rstlow.busy_cycles", busy_cnt, 0);
      chk("rstlow.rx_data", {24'd0, rx_data}, 32'h00);

      // randomized frames; model: good stop -> byte delivered, bad stop -> error, data held
      last_good = 8'h00;
      prev_bad  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         b   = 8'($urandom);
         stp = ($urandom_range(0, 3) != 0);
         gap = prev_bad ? int'($urandom_range(2, 12)) : int'($urandom_range(0, 12));
         if (gap > 0) begin
            rs232_rx = 1'b1;
            wait_cycles(gap);
         end
         send_frame(b, stp, k1);
         if (stp) begin
            last_good = b;
            push_exp(k1 + LAT, 1, b);
         end else begin
            push_exp(k1 + LAT, 2, last_good);
         end
         prev_bad = ~stp;
      end
      rs232_rx = 1'b1;
      wait_cycles(40);
      check_events("random");
      chk("random.rx_data", {24'd0, rx_data}, {24'd0, last_good});

      chk("pulse_exclusive", {31'd0, both_seen}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
